prog_axil_loader: RTL

- AXI4-Lite slave that lets the host hold the MIPS CPU in reset and stream an instruction image and data words into memory.
- Sits directly upstream of the program control / memory write-mux stage.
- Emits single-cycle write strobes with address and data, plus CPU-reset and programming status outputs.

---
 rtl/prog_pkg.sv | 19 +
 rtl/axil_wr_capture.sv | 68 ++++++
 rtl/prog_axil_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_pkg.sv
// Shared constants and types for the programming loader: register offsets,
// CTRL bit positions, AXI response codes and the session state encoding.
package prog_pkg;

  localparam int unsigned REG_CTRL       = 32'h00;
  localparam int unsigned REG_INS_DATA   = 32'h04;
  localparam int unsigned REG_DATA_ADDR  = 32'h08;
  localparam int unsigned REG_DATA_WDATA = 32'h0C;
  localparam int unsigned REG_STATUS     = 32'h10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PROG} prog_state_t;

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write handshake: captures AW and W independently, raises a
// one-cycle decode pulse once both are held, then returns the response the
// owner supplied during that pulse. Only one write is outstanding at a time.
module axil_wr_capture #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [1:0]        dec_resp,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [31:0]       cap_data,
  output logic [3:0]        cap_strb
);

  logic live_reg;
  logic aw_flag_reg;
  logic w_flag_reg;

  // Readies stay low until the first cycle after reset is released.
  assign s_awready = live_reg & ~aw_flag_reg & ~s_bvalid;
  assign s_wready  = live_reg & ~w_flag_reg & ~s_bvalid;
  assign dec_valid = aw_flag_reg & w_flag_reg & ~s_bvalid;

  // Capture flags, captured beats and the B channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_reg    <= 1'b0;
      aw_flag_reg <= 1'b0;
      w_flag_reg  <= 1'b0;
      s_bvalid    <= 1'b0;
      s_bresp     <= 2'b00;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_strb    <= '0;
    end else begin
      live_reg <= 1'b1;
      if (s_awvalid && s_awready) begin
        aw_flag_reg <= 1'b1;
        cap_addr    <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_flag_reg <= 1'b1;
        cap_data   <= s_wdata;
        cap_strb   <= s_wstrb;
      end
      if (dec_valid) begin
        s_bvalid <= 1'b1;
        s_bresp  <= dec_resp;
      end else if (s_bvalid && s_bready) begin
        s_bvalid    <= 1'b0;
        aw_flag_reg <= 1'b0;
        w_flag_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_axil_loader.sv
// Host-facing loader: holds the CPU in reset, then streams instruction and
// data words out as single-cycle write strobes under AXI4-Lite control.
module prog_axil_loader
  import prog_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int IMEM_DEPTH   = 1024,
  parameter int RST_HOLD_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       ins_wdata,
  output logic [31:0]       ins_addr,
  output logic              ins_we,
  output logic [31:0]       data_wdata,
  output logic [31:0]       data_addr,
  output logic              data_we,
  output logic              cpu_rst,
  output logic              programing
);

  localparam int CNT_W  = $clog2(IMEM_DEPTH + 1);
  localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0]  INS_LIMIT = CNT_W'(IMEM_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
  localparam logic [ADDR_W-1:0] A_INS    = ADDR_W'(REG_INS_DATA);
  localparam logic [ADDR_W-1:0] A_DADDR  = ADDR_W'(REG_DATA_ADDR);
  localparam logic [ADDR_W-1:0] A_DWDATA = ADDR_W'(REG_DATA_WDATA);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);

  prog_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]  ins_count_reg;
  logic [31:0]       data_addr_reg;
  logic [29:0]       ins_idx;
  logic [1:0]        state_bits;

  logic              wr_dec_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;
  logic              full_strb;
  logic              ins_fire, data_fire, daddr_load;

  logic              rd_live_reg;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;

  axil_wr_capture #(.ADDR_W(ADDR_W)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .dec_resp  (wr_resp),
    .dec_valid (wr_dec_valid),
    .cap_addr  (wr_addr),
    .cap_data  (wr_data),
    .cap_strb  (wr_strb)
  );

  assign full_strb  = (wr_strb == 4'hF);
  assign ins_idx    = 30'(ins_count_reg);
  assign state_bits = state_reg;
  assign cpu_rst    = (state_reg != S_IDLE);
  assign programing = (state_reg == S_PROG);

  // Session FSM, hold countdown and write decode (response + side-effect selects).
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    wr_resp       = RESP_SLVERR;
    ins_fire      = 1'b0;
    data_fire     = 1'b0;
    daddr_load    = 1'b0;
    if (state_reg == S_HOLD) begin
      if (hold_cnt_reg == '0) state_next = S_PROG;
      else hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
    end
    if (wr_dec_valid) begin
      case (wr_addr)
        A_CTRL: begin
          wr_resp = RESP_OKAY;
          if (wr_data[CTRL_START_BIT] && state_reg == S_IDLE) begin
            state_next    = S_HOLD;
            hold_cnt_next = HOLD_LOAD;
          end else if (wr_data[CTRL_DONE_BIT] && state_reg == S_PROG) begin
            state_next = S_IDLE;
          end
        end
        A_INS: begin
          if (state_reg == S_PROG && full_strb && ins_count_reg < INS_LIMIT) begin
            wr_resp  = RESP_OKAY;
            ins_fire = 1'b1;
          end
        end
        A_DADDR: begin
          if (full_strb) begin
            wr_resp    = RESP_OKAY;
            daddr_load = 1'b1;
          end
        end
        A_DWDATA: begin
          if (state_reg == S_PROG && full_strb) begin
            wr_resp   = RESP_OKAY;
            data_fire = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Write strobes, counters and the DATA_ADDR pointer; strobes land with bvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_we        <= 1'b0;
      ins_addr      <= '0;
      ins_wdata     <= '0;
      data_we       <= 1'b0;
      data_addr     <= '0;
      data_wdata    <= '0;
      ins_count_reg <= '0;
      data_addr_reg <= '0;
    end else begin
      ins_we  <= ins_fire;
      data_we <= data_fire;
      if (ins_fire) begin
        ins_addr  <= {ins_idx, 2'b00};
        ins_wdata <= wr_data;
      end
      // The count moves on as the pulse ends, so ins_addr reflects the old value.
      if (ins_we) ins_count_reg <= ins_count_reg + CNT_W'(1);
      if (state_reg == S_HOLD && state_next == S_PROG) ins_count_reg <= '0;
      if (data_fire) begin
        data_addr     <= data_addr_reg;
        data_wdata    <= wr_data;
        data_addr_reg <= data_addr_reg + 32'd4;
      end else if (daddr_load) begin
        data_addr_reg <= wr_data;
      end
    end
  end

  assign s_arready = rd_live_reg & ~s_rvalid;

  // Read mux over the current (pre-write) register state.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_araddr)
      A_CTRL:   rd_data = {30'b0, programing, cpu_rst};
      A_INS:    rd_data = '0;
      A_DADDR:  rd_data = data_addr_reg;
      A_DWDATA: rd_data = '0;
      A_STATUS: rd_data = {state_bits, 20'b0, ins_idx[9:0]};
      default:  rd_resp = RESP_SLVERR;
    endcase
  end

  // R channel: capture on accept, hold until the host takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_live_reg <= 1'b0;
      s_rvalid    <= 1'b0;
      s_rdata     <= '0;
      s_rresp     <= 2'b00;
    end else begin
      rd_live_reg <= 1'b1;
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_data;
        s_rresp  <= rd_resp;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

endmodule
